// File: rtl/video_pic_overlay.sv
// Picture overlay pixel generator: ROM picture, colour bars and background
// composited behind a latency-matched sync delay line.
module video_pic_overlay #(
  parameter int COLOR_DEPTH = 8,
  parameter int X_BITS = 12,
  parameter int Y_BITS = 12,
  parameter int H_ACT = 1280,
  parameter int V_ACT = 720,
  parameter int PIC_W = 256,
  parameter int PIC_H = 256,
  parameter int ADDR_BITS = 16,
  parameter int RD_LAT = 1,
  parameter logic [3*COLOR_DEPTH-1:0] BACK_COLOR = 24'hE0FFFF,
  parameter logic [3*COLOR_DEPTH-1:0] KEY_COLOR = 24'hFF00FF
) (
  input  logic                     pix_clk,
  input  logic                     rstn,
  input  logic [X_BITS-1:0]        act_x,
  input  logic [Y_BITS-1:0]        act_y,
  input  logic                     vs_in,
  input  logic                     hs_in,
  input  logic                     de_in,
  input  logic [1:0]               mode,
  input  logic [X_BITS-1:0]        pic_x,
  input  logic [Y_BITS-1:0]        pic_y,
  input  logic                     key_en,
  output logic [ADDR_BITS-1:0]     rom_addr,
  input  logic [3*COLOR_DEPTH-1:0] rom_rd_data,
  output logic                     vs_out,
  output logic                     hs_out,
  output logic                     de_out,
  output logic [3*COLOR_DEPTH-1:0] pixel_data
);

  localparam int PW = 3 * COLOR_DEPTH;
  localparam int BAR_W = H_ACT / 8;
  localparam logic [X_BITS-1:0] PX_RST = X_BITS'((H_ACT - PIC_W) / 2);
  localparam logic [Y_BITS-1:0] PY_RST = Y_BITS'((V_ACT - PIC_H) / 2);

  typedef struct packed {
    logic       vs;
    logic       hs;
    logic       de;
    logic       in_pic;
    logic [3:0] bar;
    logic [1:0] mode;
    logic       key;
  } meta_t;

  logic [1:0]        mode_s;
  logic [X_BITS-1:0] px_s;
  logic [Y_BITS-1:0] py_s;
  logic              key_s;
  logic              vs_q;

  logic [X_BITS-1:0] bar_cnt;
  logic [3:0]        bar_idx;

  logic [X_BITS:0]   x_end;
  logic [Y_BITS:0]   y_end;
  logic [X_BITS-1:0] dx;
  logic [Y_BITS-1:0] dy;
  logic              in_pic;
  logic [ADDR_BITS-1:0] addr_n;

  meta_t pipe [RD_LAT+1];
  meta_t s0;
  meta_t m;

  logic          br, bg, bb;
  logic [PW-1:0] bar_rgb;
  logic [PW-1:0] base;
  logic          hit;
  logic [PW-1:0] pix_n;

  assign x_end = {1'b0, px_s} + (X_BITS+1)'(PIC_W);
  assign y_end = {1'b0, py_s} + (Y_BITS+1)'(PIC_H);
  assign dx = act_x - px_s;
  assign dy = act_y - py_s;

  // Sums are one bit wider so a picture near the edge clips, never wraps
  assign in_pic = de_in
    && act_x < X_BITS'(H_ACT) && act_y < Y_BITS'(V_ACT)
    && act_x >= px_s && {1'b0, act_x} < x_end
    && act_y >= py_s && {1'b0, act_y} < y_end;

  assign addr_n = ADDR_BITS'(32'(dy) * 32'(PIC_W) + 32'(dx));

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      vs_q   <= 1'b0;
      mode_s <= 2'd1;
      px_s   <= PX_RST;
      py_s   <= PY_RST;
      key_s  <= 1'b0;
    end else begin
      vs_q <= vs_in;
      if (vs_in && !vs_q) begin
        mode_s <= mode;
        px_s   <= pic_x;
        py_s   <= pic_y;
        key_s  <= key_en;
      end
    end
  end

  // Index 8 and above selects black past the last full bar
  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (!de_in) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (bar_cnt == X_BITS'(BAR_W - 1)) begin
      bar_cnt <= '0;
      if (bar_idx != 4'd8) bar_idx <= bar_idx + 4'd1;
    end else begin
      bar_cnt <= bar_cnt + X_BITS'(1);
    end
  end

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) rom_addr <= '0;
    else if (in_pic) rom_addr <= addr_n;
  end

  always_comb begin
    s0        = '0;
    s0.vs     = vs_in;
    s0.hs     = hs_in;
    s0.de     = de_in;
    s0.in_pic = in_pic;
    s0.bar    = bar_idx;
    s0.mode   = mode_s;
    s0.key    = key_s;
  end

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i <= RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= s0;
      for (int i = 1; i <= RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign m = pipe[RD_LAT];

  assign br = !m.bar[3] && !m.bar[1];
  assign bg = !m.bar[3] && !m.bar[2];
  assign bb = !m.bar[3] && !m.bar[0];
  assign bar_rgb = {{COLOR_DEPTH{br}}, {COLOR_DEPTH{bg}}, {COLOR_DEPTH{bb}}};

  assign base = m.mode[1] ? bar_rgb : BACK_COLOR;
  assign hit = m.mode[0] && m.in_pic
    && !(m.key && rom_rd_data == KEY_COLOR);
  assign pix_n = !m.de ? BACK_COLOR : (hit ? rom_rd_data : base);

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      vs_out     <= 1'b0;
      hs_out     <= 1'b0;
      de_out     <= 1'b0;
      pixel_data <= BACK_COLOR;
    end else begin
      vs_out     <= m.vs;
      hs_out     <= m.hs;
      de_out     <= m.de;
      pixel_data <= pix_n;
    end
  end

endmodule

// File: tb/tb_video_pic_overlay.sv
// Bench for video_pic_overlay: two latencies driven in parallel and
// checked every cycle against a frame-level behavioural model.
module tb_video_pic_overlay;

  localparam int H = 1280;
  localparam int PWD = 256;
  localparam int PHT = 256;
  localparam int BW = 160;
  localparam logic [23:0] BACK = 24'hE0FFFF;
  localparam logic [23:0] KEY = 24'hFF00FF;
  localparam logic [23:0] BARS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  typedef struct packed {
    logic        vs;
    logic        hs;
    logic        de;
    logic [23:0] pix;
    logic [11:0] x;
    logic [11:0] y;
    logic [3:0]  ph;
  } ent_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] act_x = '0, act_y = '0, pic_x = '0, pic_y = '0;
  logic        vs = 1'b0, hs = 1'b0, de = 1'b0, key_en = 1'b0;
  logic [1:0]  mode = '0;

  logic [15:0] addr1, addr3;
  logic [23:0] rd1 = '0, rd3, pix1, pix3;
  logic [23:0] rd3p [3];
  logic        vs1, hs1, de1, vs3, hs3, de3;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int phase = 0;
  bit bad_addr = 1'b0;

  int s_mode = 1, s_px = 512, s_py = 232, s_key = 0, run = 0;
  bit vs_prev = 1'b0;
  ent_t hist [0:131071];

  video_pic_overlay #(.RD_LAT(1)) dut (
    .pix_clk(clk), .rstn(rstn), .act_x(act_x), .act_y(act_y),
    .vs_in(vs), .hs_in(hs), .de_in(de), .mode(mode),
    .pic_x(pic_x), .pic_y(pic_y), .key_en(key_en),
    .rom_addr(addr1), .rom_rd_data(rd1),
    .vs_out(vs1), .hs_out(hs1), .de_out(de1), .pixel_data(pix1));

  video_pic_overlay #(.RD_LAT(3)) dut3 (
    .pix_clk(clk), .rstn(rstn), .act_x(act_x), .act_y(act_y),
    .vs_in(vs), .hs_in(hs), .de_in(de), .mode(mode),
    .pic_x(pic_x), .pic_y(pic_y), .key_en(key_en),
    .rom_addr(addr3), .rom_rd_data(rd3),
    .vs_out(vs3), .hs_out(hs3), .de_out(de3), .pixel_data(pix3));

  // ROM image: data equals address, except one keyed pixel at address 5
  function automatic logic [23:0] rom_f(input logic [15:0] a);
    return (a == 16'd5) ? KEY : {8'h00, a};
  endfunction

  always @(posedge clk) rd1 <= rom_f(addr1);
  always @(posedge clk) begin
    rd3p[0] <= rom_f(addr3);
    rd3p[1] <= rd3p[0];
    rd3p[2] <= rd3p[1];
  end
  assign rd3 = rd3p[2];

  function automatic logic [23:0] model_pix(
    input logic d, input int x, input int y, input int r,
    input int m, input int px, input int py, input int k);
    bit inp;
    int a;
    logic [23:0] data, base;
    if (!d) return BACK;
    inp = x >= px && x < px + PWD && y >= py && y < py + PHT;
    a = (y - py) * PWD + (x - px);
    data = rom_f(a[15:0]);
    if (m >= 2) base = (r / BW < 8) ? BARS[r / BW] : 24'h000000;
    else base = BACK;
    if ((m % 2 == 1) && inp && !(k != 0 && data == KEY)) return data;
    return base;
  endfunction

  function automatic bit lit_exp(input ent_t e, output logic [23:0] v);
    v = '0;
    if (!e.de) return 1'b0;
    case (e.ph)
      4'd1: begin
        if (e.x == 512 && e.y == 232) begin v = 24'h000000; return 1'b1; end
        if (e.x == 767 && e.y == 487) begin v = 24'h00FFFF; return 1'b1; end
        if ((e.x == 511 || e.x == 768) && e.y == 232) begin
          v = BACK; return 1'b1;
        end
      end
      4'd2: begin
        if (e.x == 1200 && e.y == 232) begin v = 24'h000000; return 1'b1; end
        if (e.x == 1279 && e.y == 232) begin v = 24'h00004F; return 1'b1; end
        if (e.x == 1199 && e.y == 232) begin v = BACK; return 1'b1; end
        if (e.x == 1200 && e.y == 233) begin v = 24'h000100; return 1'b1; end
      end
      4'd3: begin
        if (e.x == 0) begin v = 24'hFFFFFF; return 1'b1; end
        if (e.x == 160) begin v = 24'hFFFF00; return 1'b1; end
        if (e.x == 959) begin v = 24'hFF0000; return 1'b1; end
        if (e.x == 1279) begin v = 24'h000000; return 1'b1; end
      end
      4'd4: begin
        if (e.y == 232 && e.x == 517) begin v = 24'h00FF00; return 1'b1; end
        if (e.y == 232 && e.x == 0) begin v = 24'hFFFFFF; return 1'b1; end
        if (e.y == 232 && e.x == 512) begin v = 24'h000000; return 1'b1; end
        if (e.y == 232 && e.x == 640) begin v = 24'h000080; return 1'b1; end
      end
      4'd5: begin
        if (e.y == 232 && e.x == 517) begin v = BACK; return 1'b1; end
        if (e.y == 232 && e.x == 518) begin v = 24'h000006; return 1'b1; end
      end
      4'd6: begin
        if (e.y == 232 && e.x == 517) begin v = KEY; return 1'b1; end
      end
      default: ;
    endcase
    return 1'b0;
  endfunction

  task automatic check_out(input int lat, input ent_t e,
    input logic v, input logic h, input logic d, input logic [23:0] p);
    logic [23:0] lv;
    checks++;
    if ({v, h, d, p} !== {e.vs, e.hs, e.de, e.pix}) begin
      failures++;
      $display("FAIL out_lat%0d cyc=%0d x=%0d y=%0d got vs/hs/de=%b%b%b pix=%h need %b%b%b pix=%h",
        lat, cyc, e.x, e.y, v, h, d, p, e.vs, e.hs, e.de, e.pix);
    end
    if (lit_exp(e, lv)) begin
      checks++;
      if (p !== lv) begin
        failures++;
        $display("FAIL literal_lat%0d ph=%0d x=%0d y=%0d got %h need %h",
          lat, e.ph, e.x, e.y, p, lv);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] need);
    checks++;
    if (got !== need) begin
      failures++;
      $display("FAIL %s got %h need %h", name, got, need);
    end
  endtask

  // Model update and per-cycle comparison
  always @(posedge clk) begin
    ent_t e;
    cyc++;
    e = '0;
    if (!rstn) begin
      e.pix = BACK;
      for (int i = 0; i < 5; i++) if (cyc - i >= 0) hist[cyc - i] = e;
      s_mode = 1; s_px = 512; s_py = 232; s_key = 0;
      vs_prev = 1'b0; run = 0;
    end else begin
      e.vs = vs; e.hs = hs; e.de = de;
      e.x = act_x; e.y = act_y; e.ph = 4'(phase);
      e.pix = model_pix(de, int'(act_x), int'(act_y), run,
        s_mode, s_px, s_py, s_key);
      hist[cyc] = e;
      run = de ? run + 1 : 0;
      if (vs && !vs_prev) begin
        s_mode = int'(mode); s_px = int'(pic_x);
        s_py = int'(pic_y); s_key = int'(key_en);
      end
      vs_prev = vs;
    end
    #1;
    if (cyc > 8) begin
      check_out(1, hist[cyc - 2], vs1, hs1, de1, pix1);
      check_out(3, hist[cyc - 4], vs3, hs3, de3, pix3);
    end
    if (phase == 2 && ((addr1 >= 16'd80 && addr1 <= 16'd255) ||
        (addr3 >= 16'd80 && addr3 <= 16'd255)))
      bad_addr = 1'b1;
  end

  task automatic reset_checks();
    chk("rst_pix1", 32'(pix1), 32'(BACK));
    chk("rst_pix3", 32'(pix3), 32'(BACK));
    chk("rst_sync1", {29'd0, vs1, hs1, de1}, 32'd0);
    chk("rst_sync3", {29'd0, vs3, hs3, de3}, 32'd0);
    chk("rst_addr1", 32'(addr1), 32'd0);
    chk("rst_addr3", 32'(addr3), 32'd0);
  endtask

  task automatic scramble();
    mode = 2'($urandom);
    pic_x = 12'($urandom);
    pic_y = 12'($urandom);
    key_en = 1'($urandom);
  endtask

  task automatic line(input int y, input int rst_x);
    for (int x = 0; x < H; x++) begin
      @(negedge clk);
      if (x == rst_x) begin
        rstn = 1'b0;
        #1 reset_checks();
      end
      if (x == rst_x + 2) rstn = 1'b1;
      de = 1'b1; hs = 1'b0; act_x = 12'(x); act_y = 12'(y);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      de = 1'b0; act_x = '0; hs = (i >= 5 && i < 10);
    end
  endtask

  task automatic vsync(input int m, input int px, input int py, input int k);
    mode = 2'(m); pic_x = 12'(px); pic_y = 12'(py); key_en = 1'(k);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      de = 1'b0; hs = 1'b0; vs = (i >= 2 && i < 6);
    end
    scramble();
  endtask

  initial begin
    int rm, rpx, rpy, rk, ry;
    scramble();
    repeat (10) @(negedge clk);
    reset_checks();
    rstn = 1'b1;

    // Frame without any vsync: reset shadow position and mode apply
    phase = 1;
    line(231, -1); line(232, -1); line(300, -1);
    line(487, -1); line(488, -1);

    // pic_x changes mid-frame; only the next frame may move
    phase = 0;
    vsync(1, 100, 232, 0);
    line(232, -1);
    pic_x = 12'd1200;
    line(240, -1);
    phase = 2;
    vsync(1, 1200, 232, 0);
    line(232, -1); line(233, -1);
    chk("no_addr_80_255", {31'd0, bad_addr}, 32'd0);

    phase = 3;
    vsync(2, 512, 232, 0);
    line(0, -1); line(500, -1);

    phase = 4;
    vsync(3, 512, 232, 1);
    line(232, -1); line(300, -1);

    // Keyed picture in mode 1, then reset mid-line restores shadows
    phase = 5;
    vsync(1, 512, 232, 1);
    line(232, 900);
    phase = 6;
    line(232, -1);

    phase = 0;
    for (int f = 0; f < 3; f++) begin
      rm = $urandom_range(0, 3);
      rpx = $urandom_range(0, 1400);
      rpy = $urandom_range(0, 800);
      rk = $urandom_range(0, 1);
      vsync(rm, rpx, rpy, rk);
      for (int l = 0; l < 5; l++) begin
        if ($urandom_range(0, 1) == 1) ry = $urandom_range(0, 719);
        else ry = (rpy + $urandom_range(0, 255)) % 720;
        line(ry, -1);
      end
    end

    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
